// File: rtl/fetch_pkg.sv
// Shared types and helpers for the decoupled instruction-fetch stage.
package fetch_pkg;

  // Bytes per instruction word; the PC advances by this amount per request.
  localparam int INSTR_BYTES = 4;

  // Default entry widths used by the fetch_entry_t view of a buffer slot.
  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH = 32;

  // One buffer slot: allocated flag, filled flag, PC and returned word.
  typedef struct packed {
    logic                        valid;
    logic                        filled;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  // Index width for a buffer of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer of fetched instructions.
// Three free-running pointers carry one extra wrap bit so that full/empty and
// "allocated but not yet filled" are plain pointer differences:
//   count    = alloc - read   (slots in use, including ones awaiting data)
//   unfilled = alloc - fill   (requests issued whose data has not returned)
//   head slot is allocated and filled exactly when fill != read, because
//   responses fill slots strictly in allocation order.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PW        = ptr_width(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  pop_i,
  output logic [CW-1:0]         count_o,
  output logic [CW-1:0]         unfilled_o,
  output logic                  head_valid_o,
  output logic [ADDR_WIDTH-1:0] head_pc_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  logic [CW-1:0]         alloc_q, alloc_d;
  logic [CW-1:0]         fill_q,  fill_d;
  logic [CW-1:0]         read_q,  read_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  assign count_o      = alloc_q - read_q;
  assign unfilled_o   = alloc_q - fill_q;
  assign head_valid_o = (fill_q != read_q);
  assign head_pc_o    = pc_mem_q[read_q[PW-1:0]];
  assign head_data_o  = data_mem_q[read_q[PW-1:0]];

  // Pointer next state: a flush empties the buffer and overrides all updates.
  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    read_d  = read_q;
    if (flush_i) begin
      alloc_d = {CW{1'b0}};
      fill_d  = {CW{1'b0}};
      read_d  = {CW{1'b0}};
    end else begin
      if (alloc_i) alloc_d = alloc_q + {{(CW-1){1'b0}}, 1'b1};
      else         alloc_d = alloc_q;
      if (fill_i)  fill_d  = fill_q + {{(CW-1){1'b0}}, 1'b1};
      else         fill_d  = fill_q;
      if (pop_i)   read_d  = read_q + {{(CW-1){1'b0}}, 1'b1};
      else         read_d  = read_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= {CW{1'b0}};
      fill_q  <= {CW{1'b0}};
      read_q  <= {CW{1'b0}};
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      read_q  <= read_d;
    end
  end

  // Slot storage: PC written at allocation, data written when the word returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= {ADDR_WIDTH{1'b0}};
        data_mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (alloc_i && !flush_i) pc_mem_q[alloc_q[PW-1:0]]  <= alloc_pc_i;
      if (fill_i && !flush_i)  data_mem_q[fill_q[PW-1:0]] <= fill_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checks for the fetch stage's memory-response side.
module fetch_unit_checker #(
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          rsp_valid_i,
  input logic [CW-1:0] drop_cnt_i,
  input logic [CW-1:0] unfilled_i
);

  // Every response must be owed either to the squashed stream or to an allocated slot.
  a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_i |-> ((drop_cnt_i != {CW{1'b0}}) || (unfilled_i != {CW{1'b0}})));

  // The number of responses still to be discarded can never exceed the buffer depth.
  a_drop_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    drop_cnt_i <= CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: owns the PC, issues in-order requests to an
// instruction memory of arbitrary latency, buffers returned words with their
// PCs and hands them to decode. A redirect reloads the PC, empties the buffer
// and remembers how many old responses are still on their way so they can be
// discarded; new requests are held off until those have drained.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int                    CW         = ptr_width(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INSTR_BYTES - 1));

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         count_s;
  logic [CW-1:0]         unfilled_s;
  logic                  head_valid_s;
  logic                  issue_ok_s;
  logic                  req_fire_s;
  logic                  fill_s;
  logic                  rsp_drop_s;
  logic                  pop_s;

  // Issue only while out of reset, not redirecting, not draining and not full.
  assign issue_ok_s     = rst && !redirect_valid && (drop_q == {CW{1'b0}})
                          && (count_s < CW'(DEPTH));
  assign imem_req_valid = issue_ok_s;
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = issue_ok_s && imem_req_ready;

  // A response fills a slot only when nothing is owed to a squashed stream
  // and no redirect is flushing the buffer this cycle.
  assign fill_s     = imem_rsp_valid && !redirect_valid && (drop_q == {CW{1'b0}})
                      && (unfilled_s != {CW{1'b0}});
  // A response is being discarded: either owed to an older stream, or it
  // belongs to the stream a same-cycle redirect is squashing.
  assign rsp_drop_s = imem_rsp_valid && ((drop_q != {CW{1'b0}})
                      || (redirect_valid && (unfilled_s != {CW{1'b0}})));

  assign instr_valid = rst && head_valid_s && !redirect_valid;
  assign pop_s       = instr_valid && instr_ready;

  fetch_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buffer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .flush_i      (redirect_valid),
    .alloc_i      (req_fire_s),
    .alloc_pc_i   (pc_q),
    .fill_i       (fill_s),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop_s),
    .count_o      (count_s),
    .unfilled_o   (unfilled_s),
    .head_valid_o (head_valid_s),
    .head_pc_o    (instr_pc),
    .head_data_o  (instr)
  );

  // PC next state: redirect target (word aligned) wins, else advance on a handshake.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (req_fire_s) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  // Drop counter: a redirect adds the requests still in flight, and any
  // response discarded this cycle retires one owed response.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = drop_q + unfilled_s - {{(CW-1){1'b0}}, rsp_drop_s};
    end else if (rsp_drop_s) begin
      drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end
  end

  // PC and drop-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= {CW{1'b0}};
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_unit_checker #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_checker (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rsp_valid_i (imem_rsp_valid),
    .drop_cnt_i  (drop_q),
    .unfilled_i  (unfilled_s)
  );

endmodule
